// File: rtl/malu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: op and state
// encodings plus a decoder that splits funct3 into datapath control flags.
package malu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  // funct3 of the RV32M instruction
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic x_signed;
    logic y_signed;
    logic high_half;
  } op_class_t;

  function automatic op_class_t classify_op(input op_e op);
    op_class_t c;
    c = '0;
    case (op)
      OP_MUL:    begin c.x_signed = 1'b1; c.y_signed = 1'b1; end
      OP_MULH:   begin c.x_signed = 1'b1; c.y_signed = 1'b1; c.high_half = 1'b1; end
      OP_MULHSU: begin c.x_signed = 1'b1; c.high_half = 1'b1; end
      OP_MULHU:  begin c.high_half = 1'b1; end
      OP_DIV:    begin c.is_div = 1'b1; c.x_signed = 1'b1; c.y_signed = 1'b1; end
      OP_DIVU:   begin c.is_div = 1'b1; end
      OP_REM:    begin c.is_div = 1'b1; c.is_rem = 1'b1; c.x_signed = 1'b1; c.y_signed = 1'b1; end
      OP_REMU:   begin c.is_div = 1'b1; c.is_rem = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/malu_iter.sv
// Iterative RV32M execution unit. One shared 64-bit shift register and a
// 33-bit adder/subtractor run either shift-add multiply (LSB first) or
// restoring division (MSB first) on unsigned magnitudes, one bit per cycle.
// The sign fix-up is folded into the final iteration so the result is
// registered directly into o_res when entering DONE.
module malu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_x,
  input  logic [XLEN-1:0] i_y,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res
);
  import malu_pkg::*;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]     r_opnd;    // multiplicand or divisor magnitude
  logic                r_is_div;
  logic                r_is_rem;
  logic                r_high;
  logic                r_neg;
  logic                r_ready;
  logic                r_valid;
  logic [XLEN-1:0]     r_res;

  // Request decode and operand magnitudes
  op_class_t           w_cls;
  logic                w_sx;
  logic                w_sy;
  logic [XLEN-1:0]     w_mag_x;
  logic [XLEN-1:0]     w_mag_y;
  logic                w_y_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;

  assign w_cls     = classify_op(op_e'(i_op));
  assign w_sx      = w_cls.x_signed & i_x[XLEN-1];
  assign w_sy      = w_cls.y_signed & i_y[XLEN-1];
  assign w_mag_x   = w_sx ? -i_x : i_x;
  assign w_mag_y   = w_sy ? -i_y : i_y;
  assign w_y_zero  = (i_y == '0);
  assign w_ovf     = w_cls.is_div & w_cls.x_signed & (i_x == {1'b1, {(XLEN-1){1'b0}}}) & (&i_y);
  assign w_special = w_cls.is_div & (w_y_zero | w_ovf);
  // Divide-by-zero: quotient all ones, remainder is the dividend.
  // Overflow: quotient is the dividend (most negative), remainder zero.
  assign w_special_res = w_y_zero ? (w_cls.is_rem ? i_x : '1)
                                  : (w_cls.is_rem ? '0 : i_x);

  // Shared iteration datapath
  logic [XLEN:0]       w_pr;      // shifted partial remainder for division
  logic [XLEN:0]       w_opa;
  logic [XLEN+1:0]     w_addsub;  // extra MSB is the divide borrow
  logic [XLEN:0]       w_mul_hi;
  logic                w_qbit;
  logic [XLEN-1:0]     w_rem;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_div_val;
  logic [XLEN-1:0]     w_final;

  assign w_pr      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_opa     = r_is_div ? w_pr : {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_addsub  = r_is_div ? ({1'b0, w_opa} - {2'b00, r_opnd})
                              : ({1'b0, w_opa} + {2'b00, r_opnd});
  assign w_mul_hi  = r_acc[0] ? w_addsub[XLEN:0] : {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_qbit    = ~w_addsub[XLEN+1];
  assign w_rem     = w_qbit ? w_addsub[XLEN-1:0] : w_pr[XLEN-1:0];
  assign w_acc_next = r_is_div ? {w_rem, r_acc[XLEN-2:0], w_qbit}
                               : {w_mul_hi, r_acc[XLEN-1:1]};

  // Sign correction applied to the value produced by the last iteration
  assign w_prod    = r_neg ? -w_acc_next : w_acc_next;
  assign w_div_val = r_is_rem ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  assign w_final   = r_is_div ? (r_neg ? -w_div_val : w_div_val)
                              : (r_high ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_is_rem <= 1'b0;
      r_high   <= 1'b0;
      r_neg    <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid && r_ready) begin
            r_is_div <= w_cls.is_div;
            r_is_rem <= w_cls.is_rem;
            r_high   <= w_cls.high_half;
            r_neg    <= w_cls.is_rem ? w_sx : (w_sx ^ w_sy);
            r_ready  <= 1'b0;
            r_cnt    <= '0;
            if (w_special) begin
              r_res   <= w_special_res;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, (w_cls.is_div ? w_mag_x : w_mag_y)};
              r_opnd  <= w_cls.is_div ? w_mag_y : w_mag_x;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_cnt   <= '0;
            r_res   <= w_final;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_res   = r_res;

endmodule

// File: doc/malu_iter.md
Name: malu_iter

Overview:
- Multi-cycle, area-lean RV32M execution unit. Issues MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU from the execute stage over a valid/ready request channel.
- Returns the 32-bit result over a valid/ready response channel.
- Acts as the sequential responder the pipeline stalls on in place of the single-cycle combinational multiply/divide path.
- Op encoding is funct3 of the RV32M instruction.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request.
- i_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_x  input  32  rs1 operand.
- i_y  input  32  rs2 operand.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_res  output  32  result.

Behaviour:
- Clocking/reset: one clock domain, i_clk; i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_res=0, counter=0.
- Reset during CALC or DONE aborts the operation. The result is discarded and never presented.
- States:
  - IDLE: o_ready=1. i_valid&o_ready latches op, operands, and sign flags.
    - Normal ops go to CALC.
    - Special divide cases go directly to DONE.
  - CALC: o_ready=0. Runs exactly 32 iterations, counter 0..31, one iteration per cycle. After the 32nd iteration, goes to DONE with the sign-corrected result registered.
  - DONE: o_valid=1, o_res stable.
    - i_ready=1 goes to IDLE.
    - o_valid/o_res hold until accepted.
    - No new request is accepted in DONE; o_ready=0.
- Latency: accept at edge N, CALC occupies N+1..N+32, o_valid high from edge N+33. Special cases: o_valid from edge N+1.
- Throughput: one op per 34 cycles minimum. o_ready rises the cycle after the response handshake.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: x signed, y unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Magnitudes: the core operates on unsigned 32-bit magnitudes; the result is negated at the end if required.
- Multiply:
  - Shift-add, 64-bit product accumulator, multiplier LSB-first.
  - Product sign = sx XOR sy for signed-signed. For MULHSU, product sign = sx only.
  - The 64-bit product is negated (two's complement over 64 bits) before selection.
  - MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide:
  - Restoring division, one quotient bit per cycle, MSB-first, 33-bit partial remainder.
  - Quotient sign = sx XOR sy; remainder sign = sx (dividend).
- Special cases, detected in IDLE at accept:
  - y==0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = x unchanged.
  - Signed overflow (DIV/REM with x=0x80000000 and y=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Multiply has no special cases; 0 operands take the full 32 cycles.
- Simultaneous events:
  - i_valid held while o_ready=0 is ignored; the requester must hold it.
  - Requests sampled only when both are high.
  - i_ready outside DONE has no effect.

Decomposition:
- malu_pkg holds:
  - The op enum (funct3 values above).
  - The state enum {IDLE, CALC, DONE}.
  - XLEN.
  - A function classify_op returning is_div, is_rem, x_signed, y_signed, high_half.
- No sub-module. The iteration datapath is a single shared 64-bit shift register plus a 33-bit adder/subtractor, reused by multiply and divide.

Test Plan:
- MUL x=7, y=-3 (0xFFFFFFFD) -> o_res=0xFFFFFFEB after exactly 33 cycles. MULH on the same operands -> 0xFFFFFFFF. MULHU on the same operands -> 0x00000006.
- MULHSU x=-1, y=0xFFFFFFFF -> 0xFFFFFFFF. MULH x=0x80000000, y=0x80000000 -> 0x40000000.
- DIV x=-7, y=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU x=0xFFFFFFFE, y=2 -> 0x7FFFFFFF.
- DIVU x=5, y=0 -> 0xFFFFFFFF with o_valid one cycle after accept. REM x=5, y=0 -> 5. DIV x=0x80000000, y=-1 -> 0x80000000. REM on the same operands -> 0.
- Back-pressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_res stable, o_ready=0. Then pulse i_ready -> o_ready=1 the next cycle, and a queued i_valid is accepted.
- Assert i_rst at iteration 15 of DIVU 100/7 -> next cycle o_valid=0, o_ready=1. A new MUL 3*4 then returns 12 with no stale result emitted.
